patch_embed_reader: RTL

- Read-side sequencer for the patch-embedding RAM.
- Waits for the embed stage to finish writing, then walks the RAM linearly over NUM_WORDS addresses and streams each word downstream on a valid/ready interface.
- Each word packs 32 two-bit embedded values: bit 2k is the sum, bit 2k+1 is the carry.
- Absorbs the fixed 2-clk RAM read latency with a credit-limited output FIFO, so downstream backpressure never drops or duplicates a word.

---
 rtl/patch_embed_reader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/patch_embed_reader.sv
// Read-side sequencer for the patch-embedding RAM: waits for the embed stage, walks NUM_WORDS
// addresses and streams each returned word through a credit-limited FIFO onto a valid/ready port.
module patch_embed_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_WORDS  = 1024,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  i_start,
  input  logic                  i_ramout_ready,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_ramout_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [CNT_W:0]        DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, ISSUE, DRAIN, DONE} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] issue_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  pipe_vld_q  [RD_LATENCY];
  logic                  pipe_last_q [RD_LATENCY];
  logic [CNT_W-1:0]      inflight_q;
  logic [CNT_W-1:0]      inflight_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic [CNT_W:0]        credit_used;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  last_issue;

  // A pop in this cycle frees its slot immediately, which keeps full throughput at one word/clk.
  always_comb begin
    o_valid     = (count_q != '0);
    pop         = o_valid & i_ready;
    push        = pipe_vld_q[RD_LATENCY-1];
    credit_used = {1'b0, inflight_q} + {1'b0, count_q} - (CNT_W + 1)'(pop);
    issue       = (state_q == ISSUE) && (credit_used < DEPTH_C);
    last_issue  = issue && (issue_addr_q == LAST_ADDR);
    inflight_d  = inflight_q + CNT_W'(issue) - CNT_W'(push);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign o_rd_addr = issue ? issue_addr_q : rd_addr_q;
  assign o_data    = fifo_data_q[rd_ptr_q];
  assign o_last    = o_valid & fifo_last_q[rd_ptr_q];
  assign o_busy    = busy_q;
  assign o_done    = done_q;

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      issue_addr_q <= '0;
      rd_addr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (issue) begin
        rd_addr_q    <= issue_addr_q;
        issue_addr_q <= issue_addr_q + ADDR_WIDTH'(1);
      end
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q      <= WAIT_RDY;
            busy_q       <= 1'b1;
            issue_addr_q <= '0;
          end
        end
        WAIT_RDY: begin
          if (i_ramout_ready) state_q <= ISSUE;
        end
        ISSUE: begin
          if (last_issue) state_q <= DRAIN;
        end
        DRAIN: begin
          if (inflight_q == '0 && count_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid/last tags travel alongside the RAM access so capture lines up with the read latency.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_last_q[i] <= 1'b0;
      end
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_last_q[0] <= last_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= i_ramout_data;
        fifo_last_q[wr_ptr_q] <= pipe_last_q[RD_LATENCY-1];
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

endmodule
